// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// The even-parity helper is used wherever the parity bit is formed.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter. It counts 0..CLKS_PER_BIT-1 while enabled, wraps at each bit end,
// and reports the final cycle of a bit (bit_end) and the cycle before it (bit_pre_end).
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    // The pre-end flag lets the controller register pulses that must line up with bit_end.
    assign bit_end     = en && !clear && (count == LAST);
    assign bit_pre_end = en && !clear && (count == PRE_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte as start, 8 data bits (LSB first), optional even
// parity and 1-2 stop bits, driving an external shifter through load_data/shift/data_bit.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tx_valid,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx_ready,
    output logic [UART_DATA_BITS-1:0] piso_data,
    output logic                      load_data,
    output logic                      shift,
    input  logic                      data_bit,
    output logic                      txd,
    output logic                      tx_busy,
    output logic                      tx_done,
    output tx_state_t                 tx_state
);

    localparam logic [2:0] LAST_DATA = 3'(UART_DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic       bit_end;
    logic       bit_pre_end;
    logic [2:0] bit_cnt;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .en         (tx_state != IDLE),
        .clear      (tx_state == IDLE),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready; tx_ready is
    // high only in IDLE and tx_data is not looked at in any other cycle.
    // All outputs are registered: each is computed one edge ahead of the cycle it marks.
    // txd samples data_bit on the same edge that the shift pulse advances the shifter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state  <= IDLE;
            txd       <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            load_data <= 1'b0;
            shift     <= 1'b0;
            tx_done   <= 1'b0;
            piso_data <= '0;
            bit_cnt   <= '0;
        end else begin
            load_data <= 1'b0;
            shift     <= 1'b0;
            tx_done   <= 1'b0;
            unique case (tx_state)
                IDLE: begin
                    txd <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        piso_data <= tx_data;
                        tx_state  <= START;
                        txd       <= 1'b0;
                        load_data <= 1'b1;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                        bit_cnt   <= '0;
                    end
                end
                START: begin
                    if (bit_pre_end) shift <= 1'b1;
                    if (bit_end) begin
                        tx_state <= DATA;
                        txd      <= data_bit;
                        bit_cnt  <= '0;
                    end
                end
                DATA: begin
                    if (bit_pre_end && bit_cnt != LAST_DATA) shift <= 1'b1;
                    if (bit_end) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx_state <= PARITY;
                                txd      <= even_parity(piso_data);
                            end else begin
                                tx_state <= STOP;
                                txd      <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= data_bit;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_state <= STOP;
                        txd      <= 1'b1;
                    end
                end
                STOP: begin
                    // bit_cnt is reused here to count stop bits.
                    if (bit_pre_end && bit_cnt == LAST_STOP) tx_done <= 1'b1;
                    if (bit_end) begin
                        if (bit_cnt == LAST_STOP) begin
                            tx_state <= IDLE;
                            bit_cnt  <= '0;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: begin
                    tx_state <= IDLE;
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

    a_no_load_and_shift: assert property (@(posedge clk) disable iff (!reset)
        !(load_data && shift));
    a_busy_is_not_ready: assert property (@(posedge clk) disable iff (!reset)
        tx_busy == !tx_ready);
    a_ready_only_idle: assert property (@(posedge clk) disable iff (!reset)
        tx_ready == (tx_state == IDLE));
    a_quiet_in_idle: assert property (@(posedge clk) disable iff (!reset)
        (tx_state == IDLE) |-> !(load_data || shift || tx_done));

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl across four parameter sets, each with its own shifter, driver,
// frame-level reference model, scoreboard queue and per-cycle monitor.
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    localparam int NCFG     = 4;
    localparam int MAX_WAIT = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cfg_done    = 0;

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int N     = (g == 3) ? 2 : 4;
        localparam int P     = (g == 1 || g == 3) ? 1 : 0;
        localparam int S     = (g >= 2) ? 2 : 1;
        localparam int NBITS = 10 + P + S - 1;
        localparam logic [7:0] D0 = (g == 0) ? 8'hA5 : (g == 1) ? 8'h07 : (g == 2) ? 8'h00 : 8'h81;

        logic       rst_n, tx_valid, tx_ready, load_data, shift, data_bit, txd, tx_busy, tx_done;
        logic [7:0] tx_data, piso_data, shreg;
        tx_state_t  tx_state;
        logic [8:0] exp_q[$];

        uart_tx_ctrl #(
            .CLKS_PER_BIT(N),
            .PARITY_EN   (P),
            .STOP_BITS   (S)
        ) dut (
            .clk      (clk),
            .reset    (rst_n),
            .tx_valid (tx_valid),
            .tx_data  (tx_data),
            .tx_ready (tx_ready),
            .piso_data(piso_data),
            .load_data(load_data),
            .shift    (shift),
            .data_bit (data_bit),
            .txd      (txd),
            .tx_busy  (tx_busy),
            .tx_done  (tx_done),
            .tx_state (tx_state)
        );

        // Shifter: parallel load, shift right, LSB presented on data_bit.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n)         shreg <= '0;
            else if (load_data) shreg <= piso_data;
            else if (shift)     shreg <= shreg >> 1;
        end
        assign data_bit = shreg[0];

        task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
            vectors++;
            if (act !== req) begin
                miscompares++;
                $display("FAIL cfg%0d %s: got %0h required %0h at %0t", g, name, act, req, $time);
            end
        endtask

        // Scoreboard entry: {gap-of-one expected before this frame, byte}.
        task automatic send(input logic [7:0] d, input logic keep_valid, input logic b2b,
                            output int waited);
            tx_valid = 1'b1;
            tx_data  = d;
            waited   = 0;
            @(negedge clk);
            while (!tx_ready && waited < MAX_WAIT) begin
                waited++;
                @(negedge clk);
            end
            check("tx_ready_within_budget", tx_ready, 1'b1);
            if (!tx_ready) begin
                tx_valid = 1'b0;
                return;
            end
            exp_q.push_back({b2b, d});
            @(posedge clk);
            #1;
            if (!keep_valid) tx_valid = 1'b0;
        endtask

        task automatic check_reset_state(input string tag);
            check({tag, "_txd"}, txd, 1'b1);
            check({tag, "_tx_ready"}, tx_ready, 1'b1);
            check({tag, "_tx_busy"}, tx_busy, 1'b0);
            check({tag, "_load_data"}, load_data, 1'b0);
            check({tag, "_shift"}, shift, 1'b0);
            check({tag, "_tx_done"}, tx_done, 1'b0);
            check({tag, "_piso_data"}, piso_data, 8'h00);
            check({tag, "_state"}, 32'(tx_state), 32'(IDLE));
        endtask

        initial begin : drv
            int         w;
            logic       keep, next_keep;
            logic [7:0] d;
            rst_n    = 1'b0;
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            repeat (3) @(posedge clk);
            #1;
            check_reset_state("reset");
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            send(D0, 1'b0, 1'b0, w);
            repeat (NBITS * N + 2) @(posedge clk);
            #1;

            // Valid held across the first frame with the next byte already on tx_data.
            send(8'h3C, 1'b1, 1'b0, w);
            send(8'hC3, 1'b0, 1'b1, w);
            repeat (NBITS * N + 2) @(posedge clk);
            #1;

            // Abort during DATA bit 4, then the next byte must be taken immediately.
            send(8'($urandom_range(0, 255)), 1'b0, 1'b0, w);
            repeat (5 * N + 1) @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_state("abort");
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            send(8'h55, 1'b0, 1'b0, w);
            check("accept_after_reset_waits", w, 0);
            repeat (NBITS * N + 2) @(posedge clk);
            #1;

            keep = 1'b0;
            for (int i = 0; i < 10; i++) begin
                d         = 8'($urandom_range(0, 255));
                next_keep = (i < 9) && ($urandom_range(0, 1) == 1);
                if (!keep) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                send(d, next_keep, keep, w);
                keep = next_keep;
            end
            repeat (NBITS * N + 4) @(posedge clk);
            #1;
            check("scoreboard_drained", exp_q.size(), 0);
            cfg_done++;
        end

        initial begin : mon
            int         idle_cycles;
            int         len;
            logic       prev_busy;
            logic       aborted;
            logic [8:0] e;
            logic       bits[16];
            idle_cycles = 100;
            prev_busy   = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_busy   = 1'b0;
                    idle_cycles = 100;
                end else if (!tx_busy) begin
                    check("idle_txd", txd, 1'b1);
                    check("idle_tx_ready", tx_ready, 1'b1);
                    check("idle_pulses", {load_data, shift, tx_done}, 3'b000);
                    idle_cycles++;
                    prev_busy = 1'b0;
                end else if (prev_busy) begin
                    check("tx_busy_after_frame", tx_busy, 1'b0);
                end else begin
                    check("frame_expected", exp_q.size() != 0, 1'b1);
                    prev_busy = 1'b1;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        if (e[8]) check("idle_gap", idle_cycles, 1);
                        // Reference frame: start, data LSB first, even parity, stop bits.
                        bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) bits[1 + i] = e[i];
                        if (P == 1) bits[9] = ($countones(e[7:0]) % 2) == 1;
                        for (int s = 0; s < S; s++) bits[9 + P + s] = 1'b1;
                        len     = NBITS * N;
                        aborted = 1'b0;
                        for (int k = 0; k < len; k++) begin
                            if (k > 0) begin
                                @(negedge clk);
                                if (!rst_n) begin
                                    aborted = 1'b1;
                                    break;
                                end
                            end
                            check("txd", txd, bits[k / N]);
                            check("tx_done", tx_done, k == len - 1);
                            check("load_data", load_data, k == 0);
                            check("shift", shift, (k % N == N - 1) && (k / N < 8));
                            check("piso_data", piso_data, e[7:0]);
                            check("tx_busy", tx_busy, 1'b1);
                        end
                        if (aborted) begin
                            prev_busy   = 1'b0;
                            idle_cycles = 100;
                        end else begin
                            idle_cycles = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        wait (cfg_done == NCFG);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete, %0d of %0d configurations done", cfg_done, NCFG);
        $fatal(1, "watchdog expired");
    end

endmodule
